// File: rtl/pin_test_pkg.sv
// Shared mode encodings for the pin test sequencer.
// Undefined encodings (5..7) decode to walk-one.
package pin_test_pkg;

   localparam int unsigned MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_WALK1  = 3'd0,
      MODE_WALK0  = 3'd1,
      MODE_BOUNCE = 3'd2,
      MODE_BINARY = 3'd3,
      MODE_TOGGLE = 3'd4
   } mode_t;

   function automatic mode_t decode_mode(input logic [MODE_W-1:0] m);
      case (m)
         3'd1:    return MODE_WALK0;
         3'd2:    return MODE_BOUNCE;
         3'd3:    return MODE_BINARY;
         3'd4:    return MODE_TOGGLE;
         default: return MODE_WALK1;
      endcase
   endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divide-by-DIV tick generator: counts 0..DIV-1 while run is high,
// tick fires during the DIV-1 cycle; clear forces the count back to 0.
module step_prescaler #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/pin_test_sequencer.sv
// Board pin test sequencer: walks, bounces, counts or toggles a pin pattern.
// Macro PIN_TEST_RGB_EN enables the heartbeat and RGB LED sequencing.
module pin_test_sequencer
   import pin_test_pkg::*;
#(
   parameter int unsigned NUM_PINS = 20,
   parameter int unsigned CLK_HZ   = 12000000,
   parameter int unsigned STEP_HZ  = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        manual,
   input  logic                        step_req,
   input  logic [MODE_W-1:0]           mode,
   output logic [NUM_PINS-1:0]         pins,
   output logic [$clog2(NUM_PINS)-1:0] pos,
   output logic                        step_pulse,
   output logic                        wrap,
   output logic                        heartbeat_n,
   output logic [2:0]                  rgb_n
);

   localparam int unsigned DIV = CLK_HZ / STEP_HZ;
   localparam int unsigned PW  = $clog2(NUM_PINS);
   localparam logic [PW-1:0] LAST = PW'(NUM_PINS - 1);

   logic                tick;
   logic                step;
   logic [MODE_W-1:0]   mode_q;
   logic [PW-1:0]       pos_q;
   logic                dir_up;
   logic [NUM_PINS-1:0] count;
   logic [PW-1:0]       pos_nxt;
   logic                dir_nxt;
   logic [NUM_PINS-1:0] count_nxt;
   logic                wrap_nxt;
   logic [NUM_PINS-1:0] onehot;
   mode_t               cur;

   step_prescaler #(.DIV(DIV)) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .run   (enable & ~manual),
      .clear (enable & manual),
      .tick  (tick)
   );

   assign step = enable & (manual ? step_req : tick);
   assign cur  = decode_mode(mode_q);

   always_comb begin
      pos_nxt   = pos_q;
      dir_nxt   = dir_up;
      count_nxt = count;
      wrap_nxt  = 1'b0;
      if (mode != mode_q) begin
         pos_nxt   = '0;
         dir_nxt   = 1'b1;
         count_nxt = '0;
      end else begin
         case (cur)
            MODE_WALK1, MODE_WALK0: begin
               if (pos_q == LAST) begin
                  pos_nxt  = '0;
                  wrap_nxt = 1'b1;
               end else begin
                  pos_nxt = pos_q + 1'b1;
               end
            end
            MODE_BOUNCE: begin
               // Direction flips on arrival at an end so no end value repeats.
               pos_nxt = dir_up ? pos_q + 1'b1 : pos_q - 1'b1;
               if (pos_nxt == LAST) dir_nxt = 1'b0;
               if (pos_nxt == '0) begin
                  dir_nxt  = 1'b1;
                  wrap_nxt = 1'b1;
               end
            end
            MODE_BINARY: begin
               count_nxt = count + 1'b1;
               wrap_nxt  = &count;
            end
            MODE_TOGGLE: begin
               count_nxt[0] = ~count[0];
               wrap_nxt     = count[0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= '0;
         pos_q      <= '0;
         dir_up     <= 1'b1;
         count      <= '0;
         step_pulse <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         step_pulse <= step;
         wrap       <= step & wrap_nxt;
         if (step) begin
            mode_q <= mode;
            pos_q  <= pos_nxt;
            dir_up <= dir_nxt;
            count  <= count_nxt;
         end
      end
   end

   always_comb begin
      onehot = NUM_PINS'(1) << pos_q;
      case (cur)
         MODE_WALK0:  pins = ~onehot;
         MODE_BINARY: pins = count;
         MODE_TOGGLE: pins = {NUM_PINS{count[0]}};
         default:     pins = onehot;
      endcase
   end

   assign pos = (cur == MODE_BINARY || cur == MODE_TOGGLE) ? '0 : pos_q;

`ifdef PIN_TEST_RGB_EN
   logic [1:0] rgb_cnt;
   logic       hb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_cnt <= '0;
         hb_q    <= 1'b1;
      end else if (step) begin
         rgb_cnt <= rgb_cnt + 1'b1;
         hb_q    <= ~hb_q;
      end
   end

   assign heartbeat_n = hb_q;
   assign rgb_n       = {~(rgb_cnt == 2'd3), ~(rgb_cnt == 2'd2), ~(rgb_cnt == 2'd1)};
`else
   assign heartbeat_n = 1'b1;
   assign rgb_n       = 3'b111;
`endif

endmodule

// File: doc/pin_test_sequencer.md
PIN_TEST_SEQUENCER -- requirements
Module: pin_test_sequencer

Interface
REQ-001 Param NUM_PINS, default 20, number of driven test pins, legal 2..64.
REQ-002 Param CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-003 Param STEP_HZ, default 5, automatic step rate; DIV = CLK_HZ/STEP_HZ, integer division, legal DIV >= 2.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  high = sequencer runs; low = freeze all state.
REQ-007 manual  in  1  high = automatic steps suppressed, stepping by step_req only.
REQ-008 step_req  in  1  one step per cycle sampled high while manual=1 and enable=1.
REQ-009 mode  in  3  pattern select: 0 walk-one, 1 walk-zero, 2 bounce, 3 binary count, 4 all-toggle; 5..7 behave as 0.
REQ-010 pins  out  NUM_PINS  test pattern, combinational decode of registered state.
REQ-011 pos  out  $clog2(NUM_PINS)  current walking position; 0 in modes 3 and 4.
REQ-012 step_pulse  out  1  registered; high for exactly the first cycle a new pattern is visible.
REQ-013 wrap  out  1  registered; high together with step_pulse when the sequence returns to its start.
REQ-014 heartbeat_n  out  1  active-low heartbeat LED.
REQ-015 rgb_n  out  3  active-low RGB LED: [0] red, [1] green, [2] blue.

Function
REQ-016 Prescaler counts 0..DIV-1 while enable=1 and manual=0; an internal tick fires in the cycle the count equals DIV-1, then the count returns to 0.
REQ-017 A step is a tick (manual=0) or step_req=1 (manual=1), both gated by enable; the state updates on the edge that ends the step cycle, and step_pulse is high in the next cycle.
REQ-018 manual=1 clears and holds the prescaler at 0; enable=0 holds the prescaler, the state and the LEDs, and ignores step_req.
REQ-019 At each step, if mode differs from the latched mode_q:
- mode_q loads mode.
- pos, direction and count reset to their start values.
- wrap is not asserted.
- The step shows the new mode's start pattern.
REQ-020 Walk-one: pins = one-hot at pos; pos goes 0..NUM_PINS-1, then 0; wrap on the NUM_PINS-1 to 0 step.
REQ-021 Walk-zero: pins = bitwise inverse of walk-one, with the same pos and wrap.
REQ-022 Bounce:
- pins = one-hot at pos.
- pos goes 0,1..NUM_PINS-1,NUM_PINS-2..1,0,1..., with period 2*NUM_PINS-2.
- The direction flips at both ends, with no repeated end value.
- wrap on the step into pos 0.
REQ-023 Binary: pins = NUM_PINS-bit count, incrementing modulo 2^NUM_PINS; wrap on the all-ones to 0 step.
REQ-024 All-toggle: pins alternate all-0 then all-1, starting at all-0; wrap on the step into all-0.
REQ-025 Heartbeat: heartbeat_n toggles on every step.
REQ-026 RGB sequencing:
- A 2-bit rgb counter increments modulo 4 on every step.
- rgb_n[0] = ~(cnt==1), rgb_n[1] = ~(cnt==2), rgb_n[2] = ~(cnt==3).

Reset
REQ-027 rst has priority over enable, manual, step_req and mode in the same cycle.
REQ-028 Reset values:
- prescaler 0, mode_q 0, pos 0, direction up, count 0, rgb counter 0.
- heartbeat_n 1, step_pulse 0, wrap 0, rgb_n 3'b111.
- pins = 1 (walk-one, bit 0).
REQ-029 rst asserted mid-sequence discards the in-progress prescaler count; the first automatic step after release occurs DIV cycles after rst deasserts.

Configuration
REQ-030 Macro PIN_TEST_RGB_EN defined: the heartbeat and RGB logic of REQ-025/026 are present.
REQ-031 Macro PIN_TEST_RGB_EN undefined: heartbeat_n is tied 1, rgb_n is tied 3'b111, and the rgb and heartbeat registers are not instantiated; the port list is unchanged.

Structure
REQ-032 Shared package pin_test_pkg holds the mode encodings (MODE_WALK1, MODE_WALK0, MODE_BOUNCE, MODE_BINARY, MODE_TOGGLE) and the 3-bit mode width constant.
REQ-033 Sub-module step_prescaler holds the DIV counter and tick generation, with ports clk, rst, run, clear, tick.

Verification
REQ-034 NUM_PINS=4, CLK_HZ=10, STEP_HZ=1, mode 0, auto: pins 0001, 0010, 0100, 1000, 0001 every 10 cycles; wrap only with the 0001 return.
REQ-035 Mode 2, manual=1, eight step_req pulses: pos 1,2,3,2,1,0,1,2; wrap with the 0 only.
REQ-036 Mode 3, NUM_PINS=4: 16 manual steps end at pins 0000 with wrap=1; the previous pattern is 1111.
REQ-037 Mode switched 0 to 4 at pos 2, then one step: pins 0000, pos 0, wrap 0; next step gives 1111.
REQ-038 enable=0 for 25 cycles mid-count, then rst for 1 cycle: pins, pos and LEDs frozen during enable=0; the reset values of REQ-028 appear immediately after rst; first step 10 cycles after release.
REQ-039 PIN_TEST_RGB_EN defined: rgb_n cycles 111, 110, 101, 011, 111 over 4 steps and heartbeat_n toggles; undefined: rgb_n=111 and heartbeat_n=1 throughout.
